// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit that owns the HI/LO registers.
// Each accepted operation computes its 64-bit result at the start edge into a
// staging register. HI/LO are committed only after the fixed latency expires,
// so HI/LO never show a partial update.
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU (ops 6/7). When it is
// undefined, ops 6/7 are no-ops and no accumulate logic is built.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MADDU = 3'd7;
`endif

    localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic [63:0] res;
    logic        commit;

    logic        launch;
    logic [3:0]  lat;
    logic [63:0] res_nx;
    logic        commit_nx;

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;

    assign a_s    = $signed(a);
    assign b_s    = $signed(b);
    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide returning {remainder, quotient}. The single overflowing
    // case (most negative / -1) is pinned to quotient = dividend, remainder 0.
    // A zero divisor returns 0; the caller suppresses the commit in that case.
    function automatic logic [63:0] div_signed(input logic signed [31:0] n,
                                               input logic signed [31:0] d);
        logic signed [31:0] q;
        logic signed [31:0] r;
        if (d == 32'sd0) begin
            q = 32'sd0;
            r = 32'sd0;
        end else if (n == 32'sh8000_0000 && d == -32'sd1) begin
            q = n;
            r = 32'sd0;
        end else begin
            q = n / d;
            r = n % d;
        end
        return {r, q};
    endfunction

    // Unsigned divide returning {remainder, quotient}; zero divisor returns 0.
    function automatic logic [63:0] div_unsigned(input logic [31:0] n,
                                                 input logic [31:0] d);
        if (d == 32'd0) begin
            return 64'd0;
        end
        return {n % d, n / d};
    endfunction

    // Next-state decode and launch of a new multi-cycle operation.
    always_comb begin
        state_nx  = state;
        launch    = 1'b0;
        lat       = 4'd0;
        res_nx    = res;
        commit_nx = 1'b1;
        unique case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT: begin
                            launch = 1'b1;
                            lat    = MULT_LAT;
                            res_nx = $unsigned(prod_s);
                        end
                        OP_MULTU: begin
                            launch = 1'b1;
                            lat    = MULT_LAT;
                            res_nx = prod_u;
                        end
                        OP_DIV: begin
                            launch    = 1'b1;
                            lat       = DIV_LAT;
                            res_nx    = div_signed(a_s, b_s);
                            commit_nx = (b != 32'd0);
                        end
                        OP_DIVU: begin
                            launch    = 1'b1;
                            lat       = DIV_LAT;
                            res_nx    = div_unsigned(a, b);
                            commit_nx = (b != 32'd0);
                        end
`ifdef MDU_MADD_EN
                        OP_MADD: begin
                            launch = 1'b1;
                            lat    = MULT_LAT;
                            res_nx = {hi, lo} + $unsigned(prod_s);
                        end
                        OP_MADDU: begin
                            launch = 1'b1;
                            lat    = MULT_LAT;
                            res_nx = {hi, lo} + prod_u;
                        end
`endif
                        default: ;
                    endcase
                    if (launch) begin
                        state_nx = RUN;
                    end
                end
            end
            RUN: begin
                if (cnt <= 4'd1) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Latency counter, staging register, registered busy and HI/LO commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy   <= 1'b0;
            cnt    <= 4'd0;
            res    <= 64'd0;
            commit <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            busy <= (state_nx == RUN);
            if (launch) begin
                res    <= res_nx;
                cnt    <= lat;
                commit <= commit_nx;
            end else if (state == RUN) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1 && commit) begin
                    hi <= res[63:32];
                    lo <= res[31:0];
                end
            end
            if (state == IDLE && start && op == OP_MTHI) begin
                hi <= a;
            end
            if (state == IDLE && start && op == OP_MTLO) begin
                lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table-driven directed vectors, hand-written sequences for
// ignored starts and reset corner cases, then random operations checked
// against an arithmetic reference model of HI/LO.
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    logic [31:0] mhi = 32'd0;
    logic [31:0] mlo = 32'd0;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: HI/LO after one operation, from plain integer arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] h, input logic [31:0] l,
                         output logic [31:0] eh, output logic [31:0] el, output int lat);
        int sa, sb, q;
        longint p;
        longint unsigned acc;
        sa = $signed(x);
        sb = $signed(y);
        eh = h;
        el = l;
        lat = 0;
        case (o)
            3'd0: begin p = longint'(sa) * longint'(sb); {eh, el} = p; lat = MC; end
            3'd1: begin acc = 64'(x) * 64'(y); {eh, el} = acc; lat = MC; end
            3'd2: begin
                lat = DC;
                if (sb != 0) begin
                    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                        el = x; eh = 32'd0;
                    end else begin
                        q = sa / sb; el = q; eh = sa - q * sb;
                    end
                end
            end
            3'd3: begin
                lat = DC;
                if (y != 0) begin el = x / y; eh = x % y; end
            end
            3'd4: eh = x;
            3'd5: el = x;
`ifdef MDU_MADD_EN
            3'd6: begin acc = {h, l}; p = longint'(sa) * longint'(sb); acc = acc + p; {eh, el} = acc; lat = MC; end
            3'd7: begin acc = {h, l}; acc = acc + 64'(x) * 64'(y); {eh, el} = acc; lat = MC; end
`endif
            default: ;
        endcase
    endtask

    // Issue one op; caller is at a negedge. Returns at the negedge after busy falls.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input int elat,
                         input string name);
        logic [31:0] oh, ol;
        int n;
        oh = hi;
        ol = lo;
        n = 0;
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        while (busy === 1'b1 && n < 40) begin
            check({name, " hold_hi"}, hi, oh);
            check({name, " hold_lo"}, lo, ol);
            n++;
            @(negedge clk);
        end
        check({name, " busy_cycles"}, 32'(n), 32'(elat));
        check({name, " hi"}, hi, eh);
        check({name, " lo"}, lo, el);
        mhi = eh;
        mlo = el;
    endtask

    initial begin
        logic [31:0] eh, el, x, y;
        logic [2:0] o;
        int lat, n;

        vecs[0]  = '{32'h1111_1111, 32'h2222_2222, 3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MC};
        vecs[1]  = '{32'h0, 32'h0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MC};
        vecs[2]  = '{32'h0, 32'h0, 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
        vecs[3]  = '{32'hAAAA_5555, 32'h5555_AAAA, 3'd2, 32'd123, 32'd0, 32'hAAAA_5555, 32'h5555_AAAA, DC};
        vecs[4]  = '{32'h1, 32'h1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DC};
        vecs[5]  = '{32'h0, 32'h0, 3'd3, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, 32'h0FFF_FFFF, DC};
        vecs[6]  = '{32'h0, 32'h0, 3'd2, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DC};
        vecs[7]  = '{32'h0, 32'h0, 3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, MC};
        vecs[8]  = '{32'hDEAD_BEEF, 32'hCAFE_F00D, 3'd3, 32'd99, 32'd0, 32'hDEAD_BEEF, 32'hCAFE_F00D, DC};
`ifdef MDU_MADD_EN
        vecs[9]  = '{32'h0, 32'hFFFF_FFFF, 3'd6, 32'd1, 32'd1, 32'h1, 32'h0, MC};
        vecs[10] = '{32'h0, 32'h0, 3'd6, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFB, MC};
        vecs[11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd7, 32'd2, 32'd3, 32'h0, 32'h5, MC};
`else
        vecs[9]  = '{32'h0, 32'hFFFF_FFFF, 3'd6, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF, 0};
        vecs[10] = '{32'h0, 32'h0, 3'd6, 32'hFFFF_FFFF, 32'd5, 32'h0, 32'h0, 0};
        vecs[11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd7, 32'd2, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0};
`endif
        vecs[12] = '{32'h0, 32'h0, 3'd1, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, MC};

        // Reset state while reset is held
        #12;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Asynchronous reset mid-cycle after loading HI/LO
        do_op(3'd4, 32'hA5A5_0001, 32'd0, 32'hA5A5_0001, 32'd0, 0, "mthi_pre");
        do_op(3'd5, 32'h5A5A_0002, 32'd0, 32'hA5A5_0001, 32'h5A5A_0002, 0, "mtlo_pre");
        #2 reset = 1'b0;
        #1;
        check("async_reset hi", hi, 32'd0);
        check("async_reset lo", lo, 32'd0);
        check("async_reset busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        mhi = 32'd0; mlo = 32'd0;
        @(negedge clk);

        // Table-driven directed vectors
        for (int i = 0; i < 13; i++) begin
            do_op(3'd4, vecs[i].pre_hi, 32'd0, vecs[i].pre_hi, mlo, 0, $sformatf("v%0d mthi", i));
            do_op(3'd5, vecs[i].pre_lo, 32'd0, vecs[i].pre_hi, vecs[i].pre_lo, 0, $sformatf("v%0d mtlo", i));
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
                  vecs[i].exp_lat, $sformatf("v%0d op%0d", i, vecs[i].op));
        end

        // Starts during busy (mid-run and at the final busy edge) are ignored
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (n == 3 || n == DC - 1) begin
                start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd3;
            end else begin
                start = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        check("ignored busy_cycles", 32'(n), 32'(DC));
        check("ignored hi", hi, 32'd2);
        check("ignored lo", lo, 32'd14);
        @(negedge clk);
        check("ignored no_restart", {31'd0, busy}, 32'd0);
        check("ignored lo_kept", lo, 32'd14);
        mhi = 32'd2; mlo = 32'd14;
        do_op(3'd4, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'd14, 0, "mthi");

        // Reset during RUN aborts without commit
        start = 1'b1; op = 3'd2; a = 32'hFFFF_FFF9; b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("run busy_before_reset", {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("run_reset busy", {31'd0, busy}, 32'd0);
        check("run_reset hi", hi, 32'd0);
        check("run_reset lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("post_reset busy", {31'd0, busy}, 32'd0);
        end
        check("post_reset hi", hi, 32'd0);
        check("post_reset lo", lo, 32'd0);
        mhi = 32'd0; mlo = 32'd0;

        // Random operations against the reference model
        for (int i = 0; i < 250; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: begin x = 32'($signed(-$urandom_range(0, 100))); y = 32'($urandom_range(1, 9)); end
                3: y = 32'($signed(-$urandom_range(1, 9)));
                default: ;
            endcase
            model(o, x, y, mhi, mlo, eh, el, lat);
            do_op(o, x, y, eh, el, lat, $sformatf("rnd%0d op%0d", i, o));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit for the E stage of the five-stage pipeline. It owns the HI/LO registers and accepts one operation per `start` pulse with the forwarded rs/rt operands. It holds `busy` for a fixed latency, then commits the result to HI/LO. The hazard unit stalls D-stage HI/LO users while `start` or `busy` is high, and M-stage pipeline registers capture `hi`/`lo`.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: cycles `busy` stays high for MULT/MULTU/MADD/MADDU; legal range 1–15.
- `DIV_CYCLES`, default 10: cycles `busy` stays high for DIV/DIVU; legal range 1–15.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-low.
- `start`, input, 1: operation request, sampled at the rising edge.
- `op`, input, 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU.
- `a`, input, 32: forwarded rs value.
- `b`, input, 32: forwarded rt value.
- `busy`, output, 1: a multi-cycle operation is in flight.
- `hi`, output, 32: HI register.
- `lo`, output, 32: LO register.

## Operation
- States: IDLE and RUN. A 4-bit down-counter `cnt` and a 64-bit staging register `res` support them.
- IDLE with `start=1` and op 0–3 or 6–7:
  - Compute the result from `a`/`b` (and current HI/LO for MADD*) and store it in `res`.
  - Load `cnt` with the latency and go to RUN.
- IDLE with `start=1` and op 4/5: write `a` to HI (op 4) or LO (op 5) at that edge. `busy` stays 0.
- RUN: decrement `cnt` each edge. At the edge where `cnt` goes 1→0:
  - write `hi=res[63:32]`, `lo=res[31:0]`;
  - return to IDLE.
- `start` while `busy=1` is ignored. The pipeline guarantees it never happens; the bench checks that it has no effect.
- Arithmetic rules:
  - MULT: signed 32×32 to 64 bits.
  - MULTU: unsigned 32×32 to 64 bits.
  - DIV: signed. `lo` = quotient truncated toward zero; `hi` = remainder with the sign of the dividend.
  - DIV with `a=0x80000000`, `b=0xFFFFFFFF`: `lo=0x80000000`, `hi=0`.
  - DIVU: unsigned.
  - Division by zero still runs the full `DIV_CYCLES`, then leaves `hi`/`lo` unchanged.
  - MADD/MADDU: `{hi,lo} + a*b` (signed/unsigned), modulo 2^64. The addend is the HI/LO value at the start edge.
- HI/LO hold their previous values throughout RUN. There are no partial updates.

## Timing
- Reset values (asserted at any time, asynchronously): `busy=0`, `hi=0`, `lo=0`, `cnt=0`, `res=0`, state IDLE.
- Reset during RUN aborts the operation: no commit, and `busy` drops immediately.
- `start` accepted at edge k: `busy=1` from just after edge k until edge k+N, with N = `MULT_CYCLES` or `DIV_CYCLES`. `busy=1` lasts exactly N cycles.
- New `hi`/`lo` values are visible just after edge k+N. `busy` falls at that same edge.
- Back-to-back: a `start` at edge k+N (`busy` still 1 before that edge) is ignored. The earliest accepted follow-on `start` is at edge k+N+1.
- MTHI/MTLO accepted at edge k: the new value is visible just after edge k.
- Outputs are driven directly from registers; there is no combinational path from inputs to outputs.

## Configuration
- `MDU_MADD_EN` defined: ops 6/7 perform MADD/MADDU with `MULT_CYCLES` latency.
- `MDU_MADD_EN` undefined: ops 6/7 are no-ops. `busy` stays 0, `hi`/`lo` are unchanged, and no multiply-accumulate logic is synthesized.

## Test plan
- Reset: drive `reset=0` mid-cycle. `busy`, `hi` and `lo` must go to 0 immediately, without waiting for a clock edge.
- MULT: `a=0xFFFFFFFE` (-2), `b=3`, `start=1` for one cycle.
  - `busy` must be high for exactly 5 cycles.
  - At the falling edge of `busy`: `hi=0xFFFFFFFF`, `lo=0xFFFFFFFA`.
  - `hi`/`lo` must hold the old values throughout.
- MULTU: `a=0xFFFFFFFF`, `b=0xFFFFFFFF` must give `hi=0xFFFFFFFE`, `lo=0x00000001` after 5 cycles.
- DIV:
  - `a=-7`, `b=2`: `busy` high for 10 cycles, then `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`.
  - Divide by zero: `busy` high for 10 cycles, and `hi`/`lo` keep their prior values.
- Ignored start, then MTHI:
  - Pulse `start` (DIVU) while `busy` is high: the in-flight result is unaffected and `busy` is not extended.
  - Then MTHI with `a=0x12345678` at edge k: `hi=0x12345678` after edge k, `busy` stays 0.
- Reset during RUN, and MADD:
  - Start a DIV, assert `reset` at cycle 4: `busy` drops, `hi=lo=0`, and there is no later commit.
  - With `MDU_MADD_EN` defined: `hi=0`, `lo=0xFFFFFFFF`, MADD `a=1`, `b=1` must give `hi=1`, `lo=0`.
  - Without `MDU_MADD_EN`: the same MADD must leave `hi`/`lo` unchanged and `busy=0`.
